// File: rtl/bp_common_pkg.sv
// Common address-width constants and shared types for the
// effective-address translation stage.
package bp_common_pkg;

   localparam int bp_eaddr_width_gp = 64;
   localparam int bp_vaddr_width_gp = 22;
   localparam int bp_paddr_width_gp = 22;

   typedef enum logic [1:0] {
      e_size_byte   = 2'd0,
      e_size_half   = 2'd1,
      e_size_word   = 2'd2,
      e_size_double = 2'd3
   } bp_size_e;

   typedef struct packed {
      logic [bp_paddr_width_gp-1:0] paddr;
      logic                         page_fault;
      logic                         misaligned;
   } bp_xlate_entry_s;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with registered ready/valid; fully decouples
// the producer from consumer backpressure.
module bsg_two_fifo #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   input  logic               ready_i,
   output logic [width_p-1:0] data_o
);

   typedef enum logic [1:0] {
      e_empty = 2'd0,
      e_one   = 2'd1,
      e_full  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               v_q, ready_q;
   logic               wptr_q, rptr_q;
   logic [width_p-1:0] mem_q [2];
   logic               enq, deq;

   assign enq = v_i & ready_q;
   assign deq = v_q & ready_i;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         e_empty: if (enq) state_d = e_one;
         e_one: begin
            if (enq & ~deq)      state_d = e_full;
            else if (deq & ~enq) state_d = e_empty;
         end
         e_full: if (deq) state_d = e_one;
         default: state_d = e_empty;
      endcase
   end

   // Handshake outputs are registered from the next state so they
   // never depend combinationally on v_i or ready_i.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= e_empty;
         v_q      <= 1'b0;
         ready_q  <= 1'b1;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= (state_d != e_empty);
         ready_q <= (state_d != e_full);
         if (enq) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= ~wptr_q;
         end
         if (deq) rptr_q <= ~rptr_q;
      end
   end

   assign ready_o = ready_q;
   assign v_o     = v_q;
   assign data_o  = mem_q[rptr_q];

endmodule

// File: rtl/bp_common_eaddr_xlate.sv
// Identity effective-to-physical address stage with canonical and
// alignment checks, a 2-entry output buffer and a fault counter.
module bp_common_eaddr_xlate
   import bp_common_pkg::*;
#(
   parameter int eaddr_width_p = bp_eaddr_width_gp,
   parameter int vaddr_width_p = bp_vaddr_width_gp,
   parameter int paddr_width_p = bp_paddr_width_gp
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   output logic                     ready_o,
   input  logic [eaddr_width_p-1:0] eaddr_i,
   input  logic [1:0]               size_i,
   output logic                     v_o,
   input  logic                     ready_i,
   output logic [paddr_width_p-1:0] paddr_o,
   output logic                     page_fault_o,
   output logic                     misaligned_o,
   output logic [15:0]              fault_count_o
);

   localparam int hi_w_lp = eaddr_width_p - vaddr_width_p + 1;

   logic [hi_w_lp-1:0] hi_bits;
   logic               canonical;
   logic               misaligned;
   logic               accept;
   bp_size_e           size;
   bp_xlate_entry_s    entry_in, entry_out;
   logic [15:0]        fault_cnt_q, fault_cnt_d;

   // Sign bit plus every bit above it must agree.
   assign hi_bits   = eaddr_i[eaddr_width_p-1:vaddr_width_p-1];
   assign canonical = (&hi_bits) | ~(|hi_bits);
   assign size      = bp_size_e'(size_i);

   always_comb begin
      misaligned = 1'b0;
      unique case (size)
         e_size_byte:   misaligned = 1'b0;
         e_size_half:   misaligned = eaddr_i[0];
         e_size_word:   misaligned = |eaddr_i[1:0];
         e_size_double: misaligned = |eaddr_i[2:0];
         default:       misaligned = 1'b0;
      endcase
   end

   always_comb begin
      entry_in            = '0;
      entry_in.page_fault = ~canonical;
      entry_in.misaligned = misaligned;
      if (canonical)
         entry_in.paddr =
            bp_paddr_width_gp'(eaddr_i[paddr_width_p-1:0]);
   end

   assign accept = v_i & ready_o;

   always_comb begin
      fault_cnt_d = fault_cnt_q;
      if (accept & (entry_in.page_fault | entry_in.misaligned)
          & (fault_cnt_q != 16'hFFFF))
         fault_cnt_d = fault_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) fault_cnt_q <= '0;
      else         fault_cnt_q <= fault_cnt_d;
   end

   bsg_two_fifo #(
      .width_p($bits(bp_xlate_entry_s))
   ) u_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .v_i    (v_i),
      .ready_o(ready_o),
      .data_i (entry_in),
      .v_o    (v_o),
      .ready_i(ready_i),
      .data_o (entry_out)
   );

   assign paddr_o       = paddr_width_p'(entry_out.paddr);
   assign page_fault_o  = entry_out.page_fault;
   assign misaligned_o  = entry_out.misaligned;
   assign fault_count_o = fault_cnt_q;

endmodule

// File: tb/tb_bp_common_eaddr_xlate.sv
// Directed self-checking bench for bp_common_eaddr_xlate.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_bp_common_eaddr_xlate;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        v_i;
   logic        ready_o;
   logic [63:0] eaddr_i;
   logic [1:0]  size_i;
   logic        v_o;
   logic        ready_i;
   logic [21:0] paddr_o;
   logic        page_fault_o;
   logic        misaligned_o;
   logic [15:0] fault_count_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bp_common_eaddr_xlate dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .v_i          (v_i),
      .ready_o      (ready_o),
      .eaddr_i      (eaddr_i),
      .size_i       (size_i),
      .v_o          (v_o),
      .ready_i      (ready_i),
      .paddr_o      (paddr_o),
      .page_fault_o (page_fault_o),
      .misaligned_o (misaligned_o),
      .fault_count_o(fault_count_o)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Single request with ready_i high; checks the head one cycle later.
   task automatic send1(input string tag,
                        input logic [63:0] a,
                        input logic [1:0]  s,
                        input logic [21:0] ep,
                        input logic        epf,
                        input logic        emis,
                        input logic [15:0] ecnt);
      eaddr_i = a;
      size_i  = s;
      v_i     = 1'b1;
      @(negedge clk);
      v_i = 1'b0;
      chk({tag, "_v"}, {63'd0, v_o}, 64'd1);
      chk({tag, "_out"}, {40'd0, paddr_o, page_fault_o, misaligned_o},
          {40'd0, ep, epf, emis});
      chk({tag, "_cnt"}, {48'd0, fault_count_o}, {48'd0, ecnt});
      @(negedge clk);
   endtask

   logic [23:0] expq[$];
   int          sent, got_n, first_c, last_c, cyc;

   task automatic stream(input string tag, input bit rnd);
      expq.delete();
      sent = 0; got_n = 0; first_c = -1; last_c = -1; cyc = 0;
      while ((got_n < 100) && (cyc < 2000)) begin
         ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (v_o && ready_i) begin
            if (expq.size() == 0) begin
               chk({tag, "_extra"}, 64'd1, 64'd0);
            end else begin
               chk(tag, {40'd0, paddr_o, page_fault_o, misaligned_o},
                   {40'd0, expq.pop_front()});
            end
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            got_n++;
         end
         if (ready_o && sent < 100) begin
            v_i     = 1'b1;
            eaddr_i = 64'h1000 + 64'(sent) * 64'd8;
            size_i  = 2'd3;
            expq.push_back({22'h1000 + 22'(sent) * 22'd8, 2'b00});
            sent++;
         end else begin
            v_i = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      v_i     = 1'b0;
      ready_i = 1'b1;
      chk({tag, "_count"}, 64'(got_n), 64'd100);
      if (!rnd) chk({tag, "_span"}, 64'(last_c - first_c), 64'd99);
      @(negedge clk);
   endtask

   initial begin
      reset_i = 1'b1;
      v_i     = 1'b0;
      eaddr_i = '0;
      size_i  = '0;
      ready_i = 1'b1;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst_ready", {63'd0, ready_o}, 64'd1);
      chk("rst_v", {63'd0, v_o}, 64'd0);
      chk("rst_out", {40'd0, paddr_o, page_fault_o, misaligned_o}, 64'd0);
      chk("rst_cnt", {48'd0, fault_count_o}, 64'd0);

      send1("top", 64'h0000_0000_001F_FFF8, 2'd3, 22'h1FFFF8, 0, 0, 16'd0);
      send1("neg", 64'hFFFF_FFFF_FFE0_0000, 2'd2, 22'h200000, 0, 0, 16'd0);
      send1("ncan", 64'h0000_0000_0040_0000, 2'd2, 22'h0, 1, 0, 16'd1);
      send1("mis4", 64'h0000_0000_0000_0002, 2'd2, 22'h2, 0, 1, 16'd2);
      send1("ok2", 64'h0000_0000_0000_0002, 2'd1, 22'h2, 0, 0, 16'd2);
      send1("both", 64'h8000_0000_0000_0001, 2'd1, 22'h0, 1, 1, 16'd3);

      // Backpressure: two accepted, third held off.
      ready_i = 1'b0;
      size_i  = 2'd3;
      v_i     = 1'b1;
      eaddr_i = 64'h100;
      @(negedge clk);
      chk("bp_rdy1", {63'd0, ready_o}, 64'd1);
      eaddr_i = 64'h108;
      @(negedge clk);
      chk("bp_full", {63'd0, ready_o}, 64'd0);
      eaddr_i = 64'h110;
      @(negedge clk);
      chk("bp_hold_rdy", {63'd0, ready_o}, 64'd0);
      chk("bp_head", {42'd0, paddr_o}, 64'h100);
      ready_i = 1'b1;
      @(negedge clk);
      chk("bp_rdy_back", {63'd0, ready_o}, 64'd1);
      chk("bp_2nd", {42'd0, paddr_o}, 64'h108);
      @(negedge clk);
      v_i = 1'b0;
      chk("bp_3rd", {42'd0, paddr_o}, 64'h110);
      chk("bp_3rd_v", {63'd0, v_o}, 64'd1);
      @(negedge clk);
      chk("bp_drained", {63'd0, v_o}, 64'd0);

      stream("strm", 1'b0);
      stream("rstrm", 1'b1);

      // Fill, then reset mid-operation.
      ready_i = 1'b0;
      v_i     = 1'b1;
      eaddr_i = 64'h0000_0000_0040_0001;
      size_i  = 2'd1;
      repeat (2) @(negedge clk);
      chk("pre_rst_full", {63'd0, ready_o}, 64'd0);
      chk("pre_rst_cnt", {48'd0, fault_count_o}, 64'd5);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      chk("mrst_v", {63'd0, v_o}, 64'd0);
      chk("mrst_ready", {63'd0, ready_o}, 64'd1);
      chk("mrst_cnt", {48'd0, fault_count_o}, 64'd0);
      chk("mrst_out", {40'd0, paddr_o, page_fault_o, misaligned_o}, 64'd0);

      // Saturation: one faulting accept per cycle.
      ready_i = 1'b1;
      eaddr_i = 64'h0000_0000_0040_0000;
      size_i  = 2'd0;
      v_i     = 1'b1;
      repeat (65534) @(negedge clk);
      chk("sat_fffe", {48'd0, fault_count_o}, 64'hFFFE);
      @(negedge clk);
      chk("sat_ffff", {48'd0, fault_count_o}, 64'hFFFF);
      repeat (4465) @(negedge clk);
      v_i = 1'b0;
      chk("sat_hold", {48'd0, fault_count_o}, 64'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
